cdr_rx_sequencer: RTL
=====================

// Module: cdr_rx_sequencer
// PURPOSE
//  Sequences the CDR decision datapath of the Zigbee receiver: arms/releases it, programs samples-per-symbol,
//  hunts preamble, matches SFD, then packs recovered bits into bytes for the MAC side.
//  Sits between the decision block (consumes its data bit + bit strobe, drives its run/nb_P) and the byte sink.
// PARAMETERS
//  DEF_NB_P       6'd16  samples/symbol used when i_nb_P_cfg < 2
//  ARM_CYC        4      cycles datapath is held stopped before HUNT (>=1)
//  PREAMBLE_BITS  8      consecutive '0' bits needed to declare preamble (1..63)
//  SFD_TIMEOUT    32     bits allowed in SFD before falling back to HUNT (1..255)
//  WDOG_CYC       255    clock cycles without a bit strobe before loss of lock (2..1023)
// PORTS
//  i_clk         in   1  single clock
//  i_rst         in   1  synchronous reset, active-high
//  i_start       in   1  start request (sampled in IDLE only)
//  i_abort       in   1  return to IDLE from any state
//  i_nb_P_cfg    in   6  requested samples/symbol
//  i_bit         in   1  recovered bit, valid when i_bit_vld
//  i_bit_vld     in   1  one-cycle bit strobe from decision block
//  o_dec_run     out  1  1 = decision datapath runs, 0 = held in reset
//  o_nb_P        out  6  samples/symbol driven to decision block
//  o_state       out  3  current state encoding (cdr_pkg::seq_state_t)
//  o_sync        out  1  SFD matched; level, held through DATA
//  o_byte        out  8  assembled byte, LSB received first
//  o_byte_vld    out  1  one-cycle byte strobe
//  o_lost        out  1  one-cycle pulse on watchdog expiry
//  o_done        out  1  one-cycle pulse at frame end (0 without CDR_FRAME_LEN_EN)
// BEHAVIOUR
//  Reset: state IDLE; o_nb_P=DEF_NB_P; all other outputs 0; all counters and shift register 0.
//  States: IDLE=0, ARM=1, HUNT=2, SFD=3, DATA=4, LOST=5. Registered outputs, decoded from next state.
//  IDLE: o_dec_run=0. i_start -> latch o_nb_P = (i_nb_P_cfg<2) ? DEF_NB_P : i_nb_P_cfg; go ARM.
//  ARM: o_dec_run=0 for exactly ARM_CYC cycles, then HUNT (o_dec_run=1 from first HUNT cycle).
//  HUNT: zero-run counter +1 on bit 0 (saturating), cleared on bit 1; strobe that makes it
//   reach PREAMBLE_BITS -> SFD, shift register and SFD bit count cleared.
//  SFD: each strobe shifts i_bit into sh[7] (right shift). sh==cdr_pkg::SFD (8'hA7) after the shift
//   -> DATA, o_sync=1 next cycle. SFD_TIMEOUT strobes without match -> HUNT, zero-run counter cleared.
//  DATA: bit counter 0..7 wraps; the 8th strobe sets o_byte and pulses o_byte_vld on the next cycle
//   (latency 1 clk from strobe). o_byte holds until next byte.
//  Watchdog (HUNT/SFD/DATA): counts cycles since last strobe; cleared on strobe and state entry;
//   reaching WDOG_CYC -> LOST. LOST lasts 1 cycle: o_lost=1, o_dec_run=0, o_sync=0, then IDLE.
//  i_abort: from any non-IDLE state -> IDLE next cycle, o_dec_run=0, o_sync=0, no o_lost/o_done;
//   abort wins over a same-cycle strobe, byte completion or watchdog expiry.
//  Strobe and watchdog expiry same cycle: strobe wins (counter cleared).
//  i_start outside IDLE ignored; i_nb_P_cfg changes ignored until next start.
//  Partial byte discarded on any exit from DATA. i_rst mid-frame: same as reset, no pulses.
// CONFIGURATION
//  CDR_FRAME_LEN_EN defined: first DATA byte is PHR, emitted normally (o_byte_vld) and
//   len=PHR[6:0] latched; after len further bytes, o_done pulses with the last o_byte_vld,
//   next state IDLE, o_dec_run=0. len=0 -> o_done pulses with the PHR strobe.
//  Not defined: DATA runs until i_abort/watchdog; o_done tied 0; no length logic.
// STRUCTURE
//  cdr_pkg: seq_state_t enum (3 bit), SFD constant 8'hA7, NB_P_W=6.
//  Sub-module cdr_byte_asm: shift register + 3-bit bit counter, clear input, byte/strobe output;
//   reused for SFD window and DATA packing.
// TESTING
//  start, cfg=8, 8 zeros, bits of 0xA7 LSB first -> o_nb_P=8, o_sync=1, state DATA.
//  cfg=1 at start -> o_nb_P=16; ARM holds o_dec_run=0 exactly 4 cycles.
//  In DATA feed 0x3C LSB first -> o_byte=8'h3C, o_byte_vld 1 cycle, 1 clk after 8th strobe.
//  SFD with 32 non-matching bits -> back to HUNT, o_sync stays 0; no strobe for 255 clk -> o_lost pulse, IDLE.
//  i_abort same cycle as 8th DATA strobe -> IDLE, no o_byte_vld, no o_lost.
//  CDR_FRAME_LEN_EN: PHR=8'h02 + 2 bytes -> 3 o_byte_vld, o_done with 3rd; PHR=0 -> o_done with PHR.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared types and constants for the Zigbee CDR receive sequencer.
// The optional frame-length feature is enabled with CDR_FRAME_LEN_EN.
package cdr_pkg;

  localparam int unsigned NB_P_W = 6;
  localparam logic [7:0]  SFD    = 8'hA7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_HUNT = 3'd2,
    S_SFD  = 3'd3,
    S_DATA = 3'd4,
    S_LOST = 3'd5
  } seq_state_t;

  // States in which the decision datapath runs and the watchdog is armed
  function automatic logic is_active(input seq_state_t s);
    return (s == S_HUNT) || (s == S_SFD) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/cdr_byte_asm.sv
// LSB-first shift register with a 3-bit bit counter; used for the SFD window and DATA byte packing.
module cdr_byte_asm (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_shift,
  input  logic       i_bit,
  output logic [7:0] o_byte_c,
  output logic       o_full_c
);

  logic [7:0] sh;
  logic [2:0] cnt;

  // Byte as it will look after the current shift; full when this shift is the 8th
  always_comb begin
    o_byte_c = {i_bit, sh[7:1]};
    o_full_c = i_shift && (cnt == 3'd7);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (i_shift) begin
      sh  <= o_byte_c;
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/cdr_rx_sequencer.sv
// CDR receive sequencer: arms the decision datapath, hunts preamble, matches SFD, packs data bytes.
// Define CDR_FRAME_LEN_EN to end frames after the PHR-encoded length and pulse o_done.
module cdr_rx_sequencer
  import cdr_pkg::*;
#(
  parameter logic [NB_P_W-1:0] DEF_NB_P      = 6'd16,
  parameter int unsigned       ARM_CYC       = 4,
  parameter int unsigned       PREAMBLE_BITS = 8,
  parameter int unsigned       SFD_TIMEOUT   = 32,
  parameter int unsigned       WDOG_CYC      = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [NB_P_W-1:0] i_nb_P_cfg,
  input  logic              i_bit,
  input  logic              i_bit_vld,
  output logic              o_dec_run,
  output logic [NB_P_W-1:0] o_nb_P,
  output logic [2:0]        o_state,
  output logic              o_sync,
  output logic [7:0]        o_byte,
  output logic              o_byte_vld,
  output logic              o_lost,
  output logic              o_done
);

  localparam int unsigned ARM_W  = 8;
  localparam int unsigned ZRUN_W = 6;
  localparam int unsigned SFD_W  = 8;
  localparam int unsigned WD_W   = 10;

  seq_state_t        state, state_nxt;
  logic [NB_P_W-1:0] nb_p_nxt;
  logic [ARM_W-1:0]  arm_cnt, arm_nxt;
  logic [ZRUN_W-1:0] zrun, zrun_nxt, zrun_sat;
  logic [SFD_W-1:0]  sfd_cnt, sfd_nxt, sfd_inc;
  logic [WD_W-1:0]   wd_cnt, wd_nxt, wd_inc;
  logic              wd_expire;
  logic              asm_shift, asm_clr, asm_full;
  logic [7:0]        asm_byte;
  logic              byte_vld_nxt;
`ifdef CDR_FRAME_LEN_EN
  logic              phr_seen, phr_nxt;
  logic [6:0]        rem_cnt, rem_nxt;
  logic              done_nxt;
`endif

  assign zrun_sat  = (zrun == '1) ? zrun : zrun + ZRUN_W'(1);
  assign sfd_inc   = sfd_cnt + SFD_W'(1);
  assign wd_inc    = wd_cnt + WD_W'(1);
  assign wd_expire = (wd_inc >= WD_W'(WDOG_CYC));
  assign o_state   = state;

  cdr_byte_asm u_asm (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (asm_clr),
    .i_shift  (asm_shift),
    .i_bit    (i_bit),
    .o_byte_c (asm_byte),
    .o_full_c (asm_full)
  );

  // Next-state and counter update
  always_comb begin
    state_nxt    = state;
    nb_p_nxt     = o_nb_P;
    arm_nxt      = arm_cnt;
    zrun_nxt     = zrun;
    sfd_nxt      = sfd_cnt;
    wd_nxt       = '0;
    asm_shift    = 1'b0;
    asm_clr      = 1'b0;
    byte_vld_nxt = 1'b0;
`ifdef CDR_FRAME_LEN_EN
    phr_nxt      = phr_seen;
    rem_nxt      = rem_cnt;
    done_nxt     = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (i_start) begin
          nb_p_nxt  = (i_nb_P_cfg < NB_P_W'(2)) ? DEF_NB_P : i_nb_P_cfg;
          arm_nxt   = '0;
          zrun_nxt  = '0;
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        arm_nxt = arm_cnt + ARM_W'(1);
        if (arm_cnt == ARM_W'(ARM_CYC - 1)) state_nxt = S_HUNT;
      end
      S_HUNT: begin
        if (i_bit_vld) begin
          if (!i_bit) begin
            zrun_nxt = zrun_sat;
            if (zrun_sat >= ZRUN_W'(PREAMBLE_BITS)) begin
              sfd_nxt   = '0;
              state_nxt = S_SFD;
            end
          end else begin
            zrun_nxt = '0;
          end
        end else if (wd_expire) begin
          state_nxt = S_LOST;
        end
      end
      S_SFD: begin
        if (i_bit_vld) begin
          asm_shift = 1'b1;
          sfd_nxt   = sfd_inc;
          if (asm_byte == SFD) begin
            state_nxt = S_DATA;
`ifdef CDR_FRAME_LEN_EN
            phr_nxt   = 1'b0;
            rem_nxt   = '0;
`endif
          end else if (sfd_inc == SFD_W'(SFD_TIMEOUT)) begin
            zrun_nxt  = '0;
            state_nxt = S_HUNT;
          end
        end else if (wd_expire) begin
          state_nxt = S_LOST;
        end
      end
      S_DATA: begin
        if (i_bit_vld) begin
          asm_shift = 1'b1;
          if (asm_full) begin
            byte_vld_nxt = 1'b1;
`ifdef CDR_FRAME_LEN_EN
            // First byte is the PHR; its low 7 bits give the remaining byte count
            if (!phr_seen) begin
              phr_nxt = 1'b1;
              rem_nxt = asm_byte[6:0];
              if (asm_byte[6:0] == 7'd0) begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
              end
            end else begin
              rem_nxt = rem_cnt - 7'd1;
              if (rem_cnt == 7'd1) begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
              end
            end
`endif
          end
        end else if (wd_expire) begin
          state_nxt = S_LOST;
        end
      end
      S_LOST:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides strobes, byte completion and watchdog expiry
    if (i_abort && (state != S_IDLE)) begin
      state_nxt    = S_IDLE;
      byte_vld_nxt = 1'b0;
      asm_shift    = 1'b0;
`ifdef CDR_FRAME_LEN_EN
      done_nxt     = 1'b0;
`endif
    end

    if (is_active(state) && (state_nxt == state) && !i_bit_vld) wd_nxt = wd_inc;
    asm_clr = (state_nxt != state);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      o_nb_P     <= DEF_NB_P;
      arm_cnt    <= '0;
      zrun       <= '0;
      sfd_cnt    <= '0;
      wd_cnt     <= '0;
      o_dec_run  <= 1'b0;
      o_sync     <= 1'b0;
      o_lost     <= 1'b0;
      o_byte     <= '0;
      o_byte_vld <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_nb_P     <= nb_p_nxt;
      arm_cnt    <= arm_nxt;
      zrun       <= zrun_nxt;
      sfd_cnt    <= sfd_nxt;
      wd_cnt     <= wd_nxt;
      o_dec_run  <= is_active(state_nxt);
      o_sync     <= (state_nxt == S_DATA);
      o_lost     <= (state_nxt == S_LOST);
      o_byte_vld <= byte_vld_nxt;
      if (byte_vld_nxt) o_byte <= asm_byte;
    end
  end

`ifdef CDR_FRAME_LEN_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phr_seen <= 1'b0;
      rem_cnt  <= '0;
      o_done   <= 1'b0;
    end else begin
      phr_seen <= phr_nxt;
      rem_cnt  <= rem_nxt;
      o_done   <= done_nxt;
    end
  end
`else
  assign o_done = 1'b0;
`endif

endmodule
